// File: rtl/uart_word_assembler.sv
// uart_word_assembler: packs UART bytes little-endian into 32-bit words and buffers them in a FIFO.
// Optional partial-word idle timeout is enabled by defining UART_WORD_TIMEOUT_EN.
module uart_word_assembler #(
    parameter int FIFO_DEPTH   = 4,
    parameter int BYTE_TIMEOUT = 100000
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              in_rx_valid,
    input  logic [7:0]                        in_rx_data,
    input  logic                              in_pop,
    input  logic                              in_clear_overflow,
    output logic [31:0]                       out_word,
    output logic                              out_word_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   out_count,
    output logic [1:0]                        out_partial_bytes,
    output logic                              out_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic [1:0]    r_partial;
    logic [23:0]   r_bytes;
    logic          r_ovf;
    logic          w_push, w_full, w_empty, w_pop, w_wr, w_ovf_evt, w_expire;

    always_comb begin
        w_push    = in_rx_valid && r_partial == 2'd3;
        w_full    = r_count == CW'(FIFO_DEPTH);
        w_empty   = r_count == '0;
        w_pop     = in_pop && !w_empty;
        w_wr      = w_push && (!w_full || w_pop);
        w_ovf_evt = w_push && w_full && !w_pop;
    end

    // New bytes enter at the top and shift down, so after three bytes byte 0 sits in [7:0].
    always_ff @(posedge clk) begin
        if (in_rx_valid) r_bytes <= {in_rx_data, r_bytes[23:8]};
        if (w_wr && reset_n) r_mem[r_wptr] <= {in_rx_data, r_bytes};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_partial <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_wr) - CW'(w_pop);
            r_ovf   <= w_ovf_evt || (r_ovf && !in_clear_overflow);
            if (in_rx_valid) r_partial <= r_partial + 2'd1;
            else if (w_expire) r_partial <= '0;
        end
    end

`ifdef UART_WORD_TIMEOUT_EN
    localparam int TW = $clog2(BYTE_TIMEOUT+1);
    logic [TW-1:0] r_idle;

    // Expire on the edge where the counter would reach the limit; a byte in that cycle wins.
    assign w_expire = r_partial != 2'd0 && !in_rx_valid && r_idle == TW'(BYTE_TIMEOUT-1);

    always_ff @(posedge clk) begin
        if (!reset_n || in_rx_valid || r_partial == 2'd0) r_idle <= '0;
        else if (r_idle != TW'(BYTE_TIMEOUT)) r_idle <= r_idle + TW'(1);
    end
`else
    logic w_unused_timeout;
    assign w_expire         = 1'b0;
    assign w_unused_timeout = BYTE_TIMEOUT != 0;
`endif

    assign out_word          = r_mem[r_rptr];
    assign out_word_valid    = !w_empty;
    assign out_count         = r_count;
    assign out_partial_bytes = r_partial;
    assign out_overflow      = r_ovf;
endmodule

// File: doc/uart_word_assembler.md
UART_WORD_ASSEMBLER -- requirements
Module: uart_word_assembler

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of 32-bit words buffered; power of two, at least 2.
REQ-002 Parameter: BYTE_TIMEOUT, default 100000, number of idle clk cycles after which a partial word is discarded.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 in_rx_valid  input  1  one-cycle strobe; a received UART byte is present on in_rx_data.
REQ-006 in_rx_data  input  8  received byte.
REQ-007 in_pop  input  1  consumer strobe; removes the head word.
REQ-008 in_clear_overflow  input  1  clears out_overflow.
REQ-009 out_word  output  32  head word of the FIFO; don't-care when empty.
REQ-010 out_word_valid  output  1  high while the FIFO is non-empty.
REQ-011 out_count  output  $clog2(FIFO_DEPTH+1)  number of buffered words.
REQ-012 out_partial_bytes  output  2  bytes collected toward the word under assembly (0-3).
REQ-013 out_overflow  output  1  sticky flag; a completed word was dropped.

Function
REQ-014 Bytes are assembled little-endian: 1st byte to [7:0], 2nd to [15:8], 3rd to [23:16], 4th to [31:24].
REQ-015 Each cycle with in_rx_valid high accepts exactly one byte and increments out_partial_bytes modulo 4.
REQ-016 On the 4th byte, the completed word is pushed to the FIFO tail in the same cycle; out_word_valid/out_count reflect it on the next cycle; out_partial_bytes returns to 0.
REQ-017 out_word is driven combinationally from the head entry; no read latency; pop takes effect at the clock edge.
REQ-018 in_pop while empty is ignored; no pointer or count change.
REQ-019 Push while full, without a simultaneous pop: word is dropped, FIFO unchanged, out_overflow set; partial byte count still returns to 0.
REQ-020 Push and pop in the same cycle while full: both succeed; out_count unchanged; no overflow.
REQ-021 Push and pop in the same cycle while empty: word pushed, pop ignored; out_count becomes 1.
REQ-022 Read and write pointers wrap modulo FIFO_DEPTH; out_count never exceeds FIFO_DEPTH.
REQ-023 in_clear_overflow clears out_overflow; if an overflow event occurs in the same cycle, out_overflow stays set.
REQ-024 Idle counter: resets on every accepted byte; counts while out_partial_bytes is non-zero and in_rx_valid is low; saturates at BYTE_TIMEOUT.
REQ-025 When the idle counter reaches BYTE_TIMEOUT, the partial word is discarded: out_partial_bytes becomes 0 on the next edge; the FIFO is unaffected.
REQ-026 A byte arriving in the expiry cycle takes precedence: it is accepted as a continuation and the counter restarts.

Reset
REQ-027 While reset_n is low at a clock edge: FIFO pointers, out_count, out_partial_bytes, idle counter and out_overflow all become 0; out_word_valid is 0.
REQ-028 Reset asserted mid-word or with words buffered discards all contents; in_rx_valid and in_pop are ignored during reset.
REQ-029 The first byte after reset_n is released is taken as byte 0 of a new word.

Configuration
REQ-030 Macro UART_WORD_TIMEOUT_EN: when defined, REQ-024 to REQ-026 are implemented.
REQ-031 Without UART_WORD_TIMEOUT_EN: no idle counter exists, a partial word is held indefinitely, and BYTE_TIMEOUT has no effect.

Verification
REQ-032 Bytes 0x11,0x22,0x33,0x44 -> next cycle out_word=0x44332211, out_word_valid=1, out_count=1, out_partial_bytes=0.
REQ-033 Push 5 words with FIFO_DEPTH=4 and no pops -> out_count=4, out_overflow=1, head=first word; then 4 pops -> words 1-4 in order, out_word_valid=0.
REQ-034 FIFO full, 4th byte and in_pop in the same cycle -> out_count stays 4, out_overflow stays 0, new word at tail.
REQ-035 UART_WORD_TIMEOUT_EN, BYTE_TIMEOUT=10: 2 bytes, idle 10 cycles, then 0xAA,0xBB,0xCC,0xDD -> partial discarded, out_word=0xDDCCBBAA.
REQ-036 3 words buffered plus 2 partial bytes, reset_n low for 1 cycle -> out_count=0, out_partial_bytes=0, out_overflow=0, out_word_valid=0.
REQ-037 Overflow event with in_clear_overflow high in the same cycle -> out_overflow=1; clear alone on the next cycle -> out_overflow=0.
